bcd2bin_seq: RTL and testbench

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

---
 rtl/bcd2bin_seq.sv | 133 +++++++++++++
 tb/tb_bcd2bin_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
// Consumes one BCD digit per clock, most significant digit first, with
// acc = acc*10 + digit built from shifts and adds.
// Optional build macro: BCD_CHECK_EN. When it is defined, any consumed nibble
// above 9 flags err and forces bin_out to zero at completion. When it is not
// defined, err is tied low and such nibbles are accumulated arithmetically.
//
// state | meaning
// IDLE  | waiting for start
// CONV  | consuming one digit per clock (busy=1)
// DONE  | result valid for one cycle (done=1); start here restarts at once
module bcd2bin_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   sreg;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_nxt;
  logic [2:0]     cnt;
  logic [3:0]     dig;
  logic           last;
  logic           accept;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign dig     = sreg[W-1 -: 4];
  assign last    = (cnt == 3'(DIGITS - 1));
  // acc*10 as (acc<<3)+(acc<<1); the sum wraps modulo 2^W
  assign acc_nxt = (acc << 3) + (acc << 1) + W'(dig);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CONV:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef BCD_CHECK_EN
  logic err_int;
  logic bad_dig;
  logic err_all;

  assign bad_dig = (dig > 4'd9);
  assign err_all = err_int | bad_dig;

  // Digit datapath; an invalid digit anywhere zeroes the published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_int <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      sreg    <= bcd_in;
      acc     <= '0;
      cnt     <= '0;
      err_int <= 1'b0;
    end else if (state == CONV) begin
      sreg    <= sreg << 4;
      acc     <= acc_nxt;
      cnt     <= cnt + 3'd1;
      err_int <= err_all;
      if (last) begin
        bin_out <= err_all ? '0 : acc_nxt;
        err     <= err_all;
      end
    end
  end
`else
  assign err = 1'b0;

  // Digit datapath; result published only on the last-digit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
    end else if (accept) begin
      sreg    <= bcd_in;
      acc     <= '0;
      cnt     <= '0;
    end else if (state == CONV) begin
      sreg    <= sreg << 4;
      acc     <= acc_nxt;
      cnt     <= cnt + 3'd1;
      if (last) bin_out <= acc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed testbench for bcd2bin_seq with DIGITS=4.
// Honours BCD_CHECK_EN the same way as the design when it is defined.
module tb_bcd2bin_seq;

`ifdef BCD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [15:0] bin_out;
  logic        err;

  int checks   = 0;
  int failures = 0;

  bcd2bin_seq #(.DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated conversion: start pulsed for one cycle, fixed 4-edge latency
  task automatic conv(input string tag, input logic [15:0] val, input logic [15:0] exp_bin,
                      input logic [15:0] prev_bin, input logic exp_err);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = val;
    @(posedge clk); #1;
    chk({tag, "_busy_acc"}, {15'd0, busy}, 16'd1);
    chk({tag, "_done_acc"}, {15'd0, done}, 16'd0);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        chk({tag, "_busy_mid"}, {15'd0, busy}, 16'd1);
        chk({tag, "_done_mid"}, {15'd0, done}, 16'd0);
        chk({tag, "_hold_mid"}, bin_out, prev_bin);
      end else begin
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
        chk({tag, "_bin"}, bin_out, exp_bin);
        chk({tag, "_err"}, {15'd0, err}, {15'd0, exp_err});
      end
    end
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {15'd0, done}, 16'd0);
    chk({tag, "_bin_hold"}, bin_out, exp_bin);
  endtask

  initial begin
    bit seen;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #12;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_bin",  bin_out, 16'h0000);
    chk("rst_err",  {15'd0, err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    conv("c1234", 16'h1234, 16'h04D2, 16'h0000, 1'b0);
    conv("c9999", 16'h9999, 16'h270F, 16'h04D2, 1'b0);
    conv("c0000", 16'h0000, 16'h0000, 16'h270F, 1'b0);

    // Back-to-back: start held high; 42 -> 0x2A then 100 -> 0x64, period 5
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0042;
    @(posedge clk); #1;
    chk("b2b_a_busy", {15'd0, busy}, 16'd1);
    @(negedge clk);
    bcd_in = 16'h0100;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) chk("b2b_a_mid", {15'd0, busy}, 16'd1);
    end
    chk("b2b_a_done", {15'd0, done}, 16'd1);
    chk("b2b_a_bin",  bin_out, 16'h002A);
    @(posedge clk); #1;
    chk("b2b_b_busy", {15'd0, busy}, 16'd1);
    chk("b2b_b_done0", {15'd0, done}, 16'd0);
    chk("b2b_b_hold", bin_out, 16'h002A);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) chk("b2b_b_mid", {15'd0, done}, 16'd0);
    end
    chk("b2b_b_done", {15'd0, done}, 16'd1);
    chk("b2b_b_bin",  bin_out, 16'h0064);
    @(posedge clk); #1;
    chk("b2b_idle_busy", {15'd0, busy}, 16'd0);
    chk("b2b_idle_done", {15'd0, done}, 16'd0);

    // Start pulsed mid-conversion with a different operand: 555 -> 0x22B
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0555;
    @(posedge clk); #1;
    @(negedge clk);
    start  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h9999;
    @(posedge clk); #1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'h0000;
    @(posedge clk); #1;
    chk("ign_done_early", {15'd0, done}, 16'd0);
    @(posedge clk); #1;
    chk("ign_done", {15'd0, done}, 16'd1);
    chk("ign_bin",  bin_out, 16'h022B);
    @(posedge clk); #1;
    chk("ign_busy_after", {15'd0, busy}, 16'd0);
    chk("ign_done_after", {15'd0, done}, 16'd0);

    // Async reset after two CONV cycles
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0888;
    @(posedge clk); #1;
    @(negedge clk);
    start  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_done", {15'd0, done}, 16'd0);
    chk("arst_bin",  bin_out, 16'h0000);
    chk("arst_err",  {15'd0, err}, 16'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("arst_no_done", {15'd0, seen}, 16'd0);
    conv("c0007", 16'h0007, 16'h0007, 16'h0000, 1'b0);

    // Invalid digit: 1*1000 + 2*100 + 10*10 + 4 = 1304 = 0x0518 when unchecked
    conv("c12A4", 16'h12A4, CHK ? 16'h0000 : 16'h0518, 16'h0007, CHK);
    conv("c0001", 16'h0001, 16'h0001, CHK ? 16'h0000 : 16'h0518, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
